// File: rtl/mult9_issue_ctrl_pkg.sv
// mult9_issue_ctrl_pkg: shared Q4.12 constants, lane count and controller state encoding
package mult9_issue_ctrl_pkg;
  localparam int FRAC = 12;
  localparam logic [15:0] QMAX = 16'h7FFF;
  localparam logic [15:0] QMIN = 16'h8000;
  localparam int LANES = 9;
  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, HOLD} state_t;
endpackage

// File: rtl/mult9_issue_ctrl_sat_sum9.sv
// sat_sum9: combinational signed sum of nine Q4.12 lanes, clamped to the Q4.12 range
module sat_sum9
  import mult9_issue_ctrl_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [LANES*N-1:0] lanes,
  output logic [N-1:0]       sum
);
  logic signed [19:0] acc;
  // 20 bits hold nine full-scale lanes without overflow before clamping
  always_comb begin
    acc = '0;
    for (int i = 0; i < LANES; i++) acc = acc + 20'(signed'(lanes[i*N +: N]));
    sum = acc > 20'sd32767 ? QMAX : acc < -20'sd32768 ? QMIN : acc[N-1:0];
  end
endmodule

// File: rtl/mult9_issue_ctrl.sv
// mult9_issue_ctrl: start/busy initiator for the 9-lane Q4.12 multiplier; MULT9_SUM_EN adds saturated lane sum out_sum
module mult9_issue_ctrl
  import mult9_issue_ctrl_pkg::*;
#(
  parameter int N       = 16,
  parameter int LANES   = mult9_issue_ctrl_pkg::LANES,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*N-1:0] in_a,
  input  logic [LANES*N-1:0] in_b,
  output logic               mul_start,
  output logic [LANES*N-1:0] mul_a,
  output logic [LANES*N-1:0] mul_b,
  input  logic               mul_busy,
  input  logic [LANES*N-1:0] mul_o,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_data,
`ifdef MULT9_SUM_EN
  output logic [N-1:0]       out_sum,
`endif
  output logic               err_timeout
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic tmo;
  assign tmo = cnt == CW'(TIMEOUT - 1);
`ifdef MULT9_SUM_EN
  logic [N-1:0] sum_c;
  sat_sum9 #(.N(N)) u_sum (.lanes(mul_o), .sum(sum_c));
`endif
  // single-operation FSM; all outputs registered, timeout shares the ARM/WAIT counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err_timeout <= 1'b0;
      cnt         <= '0;
`ifdef MULT9_SUM_EN
      out_sum     <= '0;
`endif
    end else begin
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mul_a     <= in_a;
            mul_b     <= in_b;
            mul_start <= 1'b1;
            in_ready  <= 1'b0;
            state     <= ISSUE;
          end else in_ready <= 1'b1;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= ARM;
        end
        ARM, WAIT: begin
          cnt <= cnt + 1'b1;
          if (state == ARM && mul_busy) state <= WAIT;
          else if (state == WAIT && !mul_busy) begin
            out_data  <= mul_o;
            out_valid <= 1'b1;
            state     <= HOLD;
`ifdef MULT9_SUM_EN
            out_sum   <= sum_c;
`endif
          end else if (tmo) begin
            err_timeout <= 1'b1;
            out_data    <= '0;
            out_valid   <= 1'b1;
            state       <= HOLD;
`ifdef MULT9_SUM_EN
            out_sum     <= '0;
`endif
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult9_issue_ctrl.sv
// tb_mult9_issue_ctrl: directed checks of the multiplier issue controller against a small multiplier model
module tb_mult9_issue_ctrl;
  logic clk = 0, rst_n = 1;
  logic in_valid = 0, in_ready, mul_start, mul_busy, out_valid, out_ready = 0, err_timeout;
  logic [143:0] in_a = '0, in_b = '0, mul_a, mul_b, mul_o, out_data;
`ifdef MULT9_SUM_EN
  logic [15:0] out_sum;
`endif
  int n_chk = 0, n_fail = 0, nstart = 0, lat, s;
  logic stuck = 0;
  logic [3:0] mcnt;

  mult9_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_o(mul_o), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
`ifdef MULT9_SUM_EN
    .out_sum(out_sum),
`endif
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // multiplier model: busy for 4 cycles after start (the ARM cycle plus 3 in WAIT)
  always @(posedge clk or negedge rst_n)
    if (!rst_n) mcnt <= 0;
    else if (mul_start) mcnt <= 4;
    else if (mcnt != 0) mcnt <= mcnt - 1;
  assign mul_busy = !stuck && mcnt != 0;

  always_comb begin
    logic signed [31:0] p;
    mul_o = '0;
    for (int i = 0; i < 9; i++) begin
      p = $signed(mul_a[i*16 +: 16]) * $signed(mul_b[i*16 +: 16]);
      mul_o[i*16 +: 16] = p[27:12];
    end
  end

  always @(posedge clk) if (mul_start) nstart++;

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_a = {9{a}};
    in_b = {9{b}};
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    while (!out_valid && l < 200) begin
      @(posedge clk);
      #1 l++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err_timeout, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1 check("rel_in_ready", in_ready, 1);

    s = nstart;
    launch(16'h3000, 16'h2000);
    check("acc_in_ready", in_ready, 0);
    wait_valid(lat);
    check("basic_lat", lat, 6);
    check("basic_starts", nstart, s + 1);
    check("basic_data", out_data, {9{16'h6000}});
`ifdef MULT9_SUM_EN
    check("basic_sum", out_sum, 16'h7FFF);
`endif
    handshake();
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);

    launch(16'h1000, 16'h2000);
    wait_valid(lat);
    check("bp_lat", lat, 6);
    @(negedge clk);
    in_a = {9{16'h0800}};
    in_b = {9{16'h1000}};
    in_valid = 1;
    s = nstart;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("bp_data", out_data, {9{16'h2000}});
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    check("bp_mul_a_held", mul_a, {9{16'h1000}});
    check("bp_no_start", nstart, s);
    @(negedge clk) out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    check("bp_hs_no_start", nstart, s);
    check("bp_hs_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
    check("bp2_start", mul_start, 1);
    wait_valid(lat);
    check("bp2_lat", lat, 6);
    check("bp2_data", out_data, {9{16'h0800}});
`ifdef MULT9_SUM_EN
    check("sum_0800", out_sum, 16'h4800);
`endif
    handshake();

    stuck = 1;
    launch(16'h1000, 16'h1000);
    wait_valid(lat);
    check("tmo_lat", lat, 65);
    check("tmo_err", err_timeout, 1);
    check("tmo_valid", out_valid, 1);
    check("tmo_data", out_data, 0);
`ifdef MULT9_SUM_EN
    check("tmo_sum", out_sum, 0);
`endif
    handshake();
    stuck = 0;
    launch(16'h3000, 16'h2000);
    wait_valid(lat);
    check("post_tmo_lat", lat, 6);
    check("post_tmo_data", out_data, {9{16'h6000}});
    check("post_tmo_err", err_timeout, 1);
    handshake();

    launch(16'h1000, 16'h1000);
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1 check("ar_in_ready", in_ready, 0);
    check("ar_mul_start", mul_start, 0);
    check("ar_mul_a", mul_a, 0);
    check("ar_mul_b", mul_b, 0);
    check("ar_out_valid", out_valid, 0);
    check("ar_out_data", out_data, 0);
    check("ar_err", err_timeout, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1 check("ar_rel_in_ready", in_ready, 1);

`ifdef MULT9_SUM_EN
    launch(16'h2000, 16'h1000);
    wait_valid(lat);
    check("sum_2000", out_sum, 16'h7FFF);
    handshake();
    launch(16'hE000, 16'h1000);
    wait_valid(lat);
    check("sum_e000_data", out_data, {9{16'hE000}});
    check("sum_e000", out_sum, 16'h8000);
    handshake();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
